mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store front-end between the CPU MEM pipeline stage and the data RAM port (we/addr/mode/din/dout).
//  Accepts one request per valid/ready handshake and drives the RAM.
//  Splits misaligned halfword/word accesses into little-endian byte accesses, sign/zero-extends the result.
//  Range-checks addresses and returns an error response for bad requests.
// PARAMETERS
//  SIZE      10  RAM depth = 2**SIZE words; valid byte range 0 .. (4<<SIZE)-1
//  SPLIT_EN  1   1: split misaligned accesses into byte accesses; 0: misaligned -> error response
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous reset, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   unit can accept (high only in IDLE)
//  req_we      in   1   1 store, 0 load
//  req_mode    in   3   0 B, 1 H, 2 W, 4 BU, 5 HU; 3/6/7 illegal
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, LSB-aligned
//  resp_valid  out  1   one-cycle pulse: request finished
//  resp_rdata  out  32  extended load data (0 for stores/errors)
//  resp_err    out  1   qualifies resp_valid: illegal mode, out of range, or misaligned with SPLIT_EN=0
//  busy        out  1   state != IDLE
//  ram_we      out  1   RAM write enable
//  ram_addr    out  32  RAM byte address
//  ram_mode    out  3   RAM access mode (same encoding as req_mode)
//  ram_din     out  32  RAM write data
//  ram_dout    in   32  RAM combinational read data
// BEHAVIOUR
//  Reset (async): state IDLE; req_ready=1; all other outputs 0; request/assembly registers 0.
//  FSM states:
//   IDLE: handshake = req_valid & req_ready. Latch we/mode/addr/wdata; classify.
//     Error -> RESP. Aligned -> ACCESS with n=1 wide access. Misaligned split -> ACCESS with n = 2 (H) or 4 (W) byte accesses.
//   ACCESS: one RAM access per cycle; byte counter i = 0..n-1.
//     Aligned: ram_addr=addr, ram_mode=mode, ram_din=wdata, ram_we=we; capture ram_dout.
//     Split: ram_addr=addr+i, ram_mode=4 (BU), ram_din={24'b0, wdata[8i+:8]}, ram_we=we; capture ram_dout[7:0] into byte i.
//     After the last access -> RESP.
//   RESP: resp_valid=1 for exactly one cycle -> IDLE.
//  Outside ACCESS: ram_we=0; ram_addr/ram_mode/ram_din hold the latched request.
//  Misaligned definition: H with addr[0]=1; W with addr[1:0]!=0; byte accesses are never misaligned.
//  Range check, 33-bit unsigned: addr + bytes - 1 > (4<<SIZE)-1 -> error. On error, ram_we is never asserted.
//  Load extension applies to the assembled value:
//   mode 0/1 -> sign-extend from bit 7/15
//   mode 4/5 -> zero-extend
//   mode 2 -> unchanged
//  Latency from handshake in cycle N: resp_valid in cycle N+n+1 (aligned N+2, split H N+3, split W N+5); error N+1.
//  Throughput: req_ready low from N+1 until back in IDLE; req_valid while busy is ignored and not queued.
//  Back-to-back: a new handshake is allowed in the cycle after resp_valid.
//  Reset mid-ACCESS: ram_we drops immediately; bytes already written stay written; no response is produced.
//  Request inputs are sampled only at the handshake; later changes have no effect.
// TESTING
//  T1 SW 0xDEADBEEF @0x10, then LW @0x10 -> ram_we high 1 cycle at N+1; load resp_rdata=0xDEADBEEF at N+2, err=0.
//  T2 word 0x80010000 @0x0; LH @0x2 -> 0xFFFF8001; LHU @0x2 -> 0x00008001; LB @0x3 -> 0xFFFFFF80.
//  T3 SW 0x11223344 @0x5 (split) -> bytes 0x44,0x33,0x22,0x11 at 0x5..0x8 in N+1..N+4, resp N+5;
//     LW @0x5 -> 0x11223344 at N+5; LBU @0x8 -> 0x11.
//  T4 SIZE=10: LW @0xFFE and LB @0x1000 -> resp_err=1 at N+1, rdata=0, ram_we never high; LB @0xFFF -> no error.
//  T5 SPLIT_EN=0: LH @0x3 -> err at N+1; req_mode=3 -> err; req_valid held during busy -> exactly one response.
//  T6 rst asserted during the 3rd byte of a split SW @0x1 -> ram_we low the same cycle, bytes @0x1,0x2 updated,
//     @0x3,0x4 unchanged, req_ready=1 after rst released.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end between the MEM stage and the data RAM.
// Splits misaligned accesses into byte accesses, range-checks, extends loads.
module mem_access_unit #(
  parameter int SIZE     = 10,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [2:0]  ram_mode,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [32:0] LIMIT =
    (33'd4 << SIZE) - 33'd1;

  state_t      state, state_nx;
  logic        we_q, err_q, split_q;
  logic [2:0]  mode_q;
  logic [31:0] addr_q, wdata_q, data_q;
  logic [1:0]  cnt_q, cnt_last;

  logic [2:0]  nbytes;
  logic        illegal, misal, oor, bad;
  logic [32:0] end_addr;
  logic        hs, in_acc, in_split;
  logic [4:0]  bsel;
  logic [31:0] ext;

  assign hs = req_valid && (state == IDLE);

  always_comb begin
    nbytes  = 3'd1;
    illegal = 1'b0;
    case (req_mode)
      3'd0, 3'd4: nbytes = 3'd1;
      3'd1, 3'd5: nbytes = 3'd2;
      3'd2:       nbytes = 3'd4;
      default:    illegal = 1'b1;
    endcase
  end

  assign misal =
    (nbytes == 3'd2 && req_addr[0]) ||
    (nbytes == 3'd4 && req_addr[1:0] != 2'b00);

  // 33-bit sum so a request ending past 2^32 still flags
  assign end_addr = {1'b0, req_addr}
                  + {30'd0, nbytes} - 33'd1;
  assign oor = end_addr > LIMIT;
  assign bad = illegal || oor
            || (misal && !SPLIT_EN);

  assign cnt_last =
    !split_q           ? 2'd0 :
    (mode_q == 3'd2)   ? 2'd3 : 2'd1;

  assign bsel = {cnt_q, 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
      mode_q  <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      data_q  <= 32'd0;
      cnt_q   <= 2'd0;
    end else begin
      state <= state_nx;
      if (hs) begin
        we_q    <= req_we;
        mode_q  <= req_mode;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= bad;
        split_q <= misal && SPLIT_EN;
        cnt_q   <= 2'd0;
        data_q  <= 32'd0;
      end else if (in_acc) begin
        cnt_q <= cnt_q + 2'd1;
        if (split_q)
          data_q[bsel +: 8] <= ram_dout[7:0];
        else
          data_q <= ram_dout;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (req_valid)
          state_nx = bad ? RESP : ACCESS;
      ACCESS:
        if (cnt_q == cnt_last)
          state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ext = data_q;
    unique case (1'b1)
      mode_q == 3'd0:
        ext = {{24{data_q[7]}}, data_q[7:0]};
      mode_q == 3'd1:
        ext = {{16{data_q[15]}}, data_q[15:0]};
      mode_q == 3'd4:
        ext = {24'd0, data_q[7:0]};
      mode_q == 3'd5:
        ext = {16'd0, data_q[15:0]};
      default: ext = data_q;
    endcase
  end

  assign in_acc   = (state == ACCESS);
  assign in_split = in_acc && split_q;

  assign ram_we   = in_acc && we_q;
  assign ram_addr = in_split
                  ? addr_q + {30'd0, cnt_q}
                  : addr_q;
  assign ram_mode = in_split ? 3'd4 : mode_q;
  assign ram_din  = in_split
                  ? {24'd0, wdata_q[bsel +: 8]}
                  : wdata_q;

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata =
    (resp_valid && !err_q && !we_q)
    ? ext : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit
// against a byte-wide RAM model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_mode = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;
  logic        ram_we;
  logic [31:0] ram_addr, ram_din, ram_dout;
  logic [2:0]  ram_mode;

  logic        v0 = 1'b0;
  logic [2:0]  m0 = 3'd0;
  logic [31:0] a0 = 32'd0;
  logic        rdy0, rv0, re0, busy0, we0;
  logic [31:0] rd0, ra0, rdin0;
  logic [2:0]  rm0;

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0]  mem [0:4095];
  logic [11:0] ma;

  always #5 clk = ~clk;

  mem_access_unit #(.SIZE(10), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_mode(req_mode),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy),
    .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_mode(ram_mode), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  mem_access_unit #(.SIZE(10), .SPLIT_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(v0), .req_ready(rdy0),
    .req_we(1'b0), .req_mode(m0),
    .req_addr(a0), .req_wdata(32'd0),
    .resp_valid(rv0), .resp_rdata(rd0),
    .resp_err(re0), .busy(busy0),
    .ram_we(we0), .ram_addr(ra0),
    .ram_mode(rm0), .ram_din(rdin0),
    .ram_dout(32'd0)
  );

  always_comb begin
    ma = ram_addr[11:0];
    ram_dout = 32'd0;
    case (ram_mode)
      3'd0, 3'd4: ram_dout = {24'd0, mem[ma]};
      3'd1, 3'd5:
        ram_dout = {16'd0, mem[ma + 12'd1], mem[ma]};
      3'd2:
        ram_dout = {mem[ma + 12'd3], mem[ma + 12'd2],
                    mem[ma + 12'd1], mem[ma]};
      default: ram_dout = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr[11:0]] <= ram_din[7:0];
      if (ram_mode == 3'd1 || ram_mode == 3'd5 ||
          ram_mode == 3'd2)
        mem[ram_addr[11:0] + 12'd1] <= ram_din[15:8];
      if (ram_mode == 3'd2) begin
        mem[ram_addr[11:0] + 12'd2] <= ram_din[23:16];
        mem[ram_addr[11:0] + 12'd3] <= ram_din[31:24];
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present a request for one cycle; returns in cycle N+1
  task automatic issue(input logic we,
                       input logic [2:0] m,
                       input logic [31:0] a,
                       input logic [31:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_mode  = m;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h5A5A_5A5A;
    req_mode  = 3'd7;
  endtask

  task automatic run(input string tag,
                     input logic we,
                     input logic [2:0] m,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input int lat,
                     input logic err,
                     input logic [31:0] exp);
    int wes;
    wes = 0;
    issue(we, m, a, d);
    for (int k = 1; k < lat; k++) begin
      chk({tag, "_early"}, {31'd0, resp_valid}, 32'd0);
      if (ram_we) wes++;
      tick();
    end
    chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, err});
    chk({tag, "_rdata"}, resp_rdata, exp);
    chk({tag, "_wecnt"}, wes,
        (!err && we) ? lat - 1 : 0);
    tick();
  endtask

  initial begin
    int pulses;
    logic [31:0] w;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rv", {31'd0, resp_valid}, 32'd0);
    chk("rst_we", {31'd0, ram_we}, 32'd0);
    chk("rst_addr", ram_addr, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // T1
    issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    chk("t1_we", {31'd0, ram_we}, 32'd1);
    chk("t1_addr", ram_addr, 32'h10);
    chk("t1_din", ram_din, 32'hDEADBEEF);
    chk("t1_rdy", {31'd0, req_ready}, 32'd0);
    tick();
    chk("t1_we2", {31'd0, ram_we}, 32'd0);
    chk("t1_rv", {31'd0, resp_valid}, 32'd1);
    chk("t1_serr", {31'd0, resp_err}, 32'd0);
    tick();
    run("t1_lw", 1'b0, 3'd2, 32'h10, 0, 2, 1'b0, 32'hDEADBEEF);

    // T2
    run("t2_sw", 1'b1, 3'd2, 32'h0, 32'h80010000, 2, 1'b0, 0);
    run("t2_lh", 1'b0, 3'd1, 32'h2, 0, 2, 1'b0, 32'hFFFF8001);
    run("t2_lhu", 1'b0, 3'd5, 32'h2, 0, 2, 1'b0, 32'h00008001);
    run("t2_lb", 1'b0, 3'd0, 32'h3, 0, 2, 1'b0, 32'hFFFFFF80);

    // T3
    w = 32'h11223344;
    issue(1'b1, 3'd2, 32'h5, w);
    for (int i = 0; i < 4; i++) begin
      chk("t3_we", {31'd0, ram_we}, 32'd1);
      chk("t3_addr", ram_addr, 32'h5 + i);
      chk("t3_mode", {29'd0, ram_mode}, 32'd4);
      chk("t3_din", ram_din, (w >> (8 * i)) & 32'hFF);
      tick();
    end
    chk("t3_rv", {31'd0, resp_valid}, 32'd1);
    chk("t3_serr", {31'd0, resp_err}, 32'd0);
    tick();
    run("t3_lw", 1'b0, 3'd2, 32'h5, 0, 5, 1'b0, 32'h11223344);
    run("t3_lbu", 1'b0, 3'd4, 32'h8, 0, 2, 1'b0, 32'h11);
    run("t3_lh", 1'b0, 3'd1, 32'h7, 0, 3, 1'b0, 32'h00001122);

    // T4
    run("t4_sw", 1'b1, 3'd2, 32'hFFC, 32'h7F000000, 2, 1'b0, 0);
    run("t4_lw_oor", 1'b0, 3'd2, 32'hFFE, 0, 1, 1'b1, 0);
    run("t4_lb_oor", 1'b0, 3'd0, 32'h1000, 0, 1, 1'b1, 0);
    run("t4_sb_oor", 1'b1, 3'd0, 32'h1000, 32'hFF, 1, 1'b1, 0);
    run("t4_lb_ok", 1'b0, 3'd0, 32'hFFF, 0, 2, 1'b0, 32'h7F);
    run("t4_mode3", 1'b0, 3'd3, 32'h0, 0, 1, 1'b1, 0);

    // T5 (no split)
    v0 = 1'b1; m0 = 3'd1; a0 = 32'h3;
    tick();
    v0 = 1'b0;
    chk("t5_lh_rv", {31'd0, rv0}, 32'd1);
    chk("t5_lh_err", {31'd0, re0}, 32'd1);
    tick();
    v0 = 1'b1; m0 = 3'd6; a0 = 32'h0;
    tick();
    v0 = 1'b0;
    chk("t5_m6_err", {31'd0, re0}, 32'd1);
    tick();
    v0 = 1'b1; m0 = 3'd2; a0 = 32'h0;
    tick();
    chk("t5_rdy", {31'd0, rdy0}, 32'd0);
    chk("t5_busy", {31'd0, busy0}, 32'd1);
    tick();
    chk("t5_rv", {31'd0, rv0}, 32'd1);
    chk("t5_ok", {31'd0, re0}, 32'd0);
    v0 = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (rv0) pulses++;
    end
    chk("t5_pulses", pulses, 0);

    // T6
    run("t6_sw0", 1'b1, 3'd2, 32'h0, 32'hAABBCCDD, 2, 1'b0, 0);
    run("t6_sw4", 1'b1, 3'd2, 32'h4, 32'h55667788, 2, 1'b0, 0);
    issue(1'b1, 3'd2, 32'h1, 32'h11223344);
    tick();
    tick();
    chk("t6_addr", ram_addr, 32'h3);
    chk("t6_we", {31'd0, ram_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_we_rst", {31'd0, ram_we}, 32'd0);
    chk("t6_busy_rst", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_rdy", {31'd0, req_ready}, 32'd1);
    chk("t6_rv", {31'd0, resp_valid}, 32'd0);
    run("t6_lw", 1'b0, 3'd2, 32'h0, 0, 2, 1'b0, 32'hAA3344DD);
    run("t6_lbu4", 1'b0, 3'd4, 32'h4, 0, 2, 1'b0, 32'h88);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
